// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment receive path: segment patterns and FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    typedef enum logic [1:0] {
        WAIT_BLANK,
        ARMED,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to hex nibble decoder; blank and unknown patterns are not legal digits.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = '0;
        legal  = 1'b1;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_word_receiver.sv
// Debounces a 7-segment bus, decodes blank-delimited digits and assembles them into words
// presented on a valid/ready output.
module seg7_word_receiver
    import seg7_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int NIBBLES       = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [6:0]                 seg_in,
    input  logic                       enable,
    output logic [NIBBLES*WIDTH-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err,
    output logic                       ovf
);

    localparam int WORD_W = NIBBLES * WIDTH;
    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
    // The counter is compared before it increments, so qualification happens when it holds S-2.
    localparam logic [7:0] QUAL_AT  = (STABLE_CYCLES >= 2) ? 8'(STABLE_CYCLES - 2) : 8'd0;
    localparam logic [3:0] LAST_DIGIT = 4'(NIBBLES - 1);

    logic [6:0]        eff;
    logic [6:0]        seg_q;
    logic [7:0]        stab_cnt;
    logic [3:0]        nibble;
    logic              legal;
    logic              same;
    logic              qual;
    logic              blank;

    state_t            state_q, state_d;
    logic [3:0]        digit_cnt_q, digit_cnt_d;
    logic [WORD_W-1:0] asm_q, asm_d, shifted;
    logic [WORD_W-1:0] data_d;
    logic              valid_d, err_d, ovf_d;

    assign eff   = enable ? seg_in : SEG_BLANK;
    assign same  = (eff == seg_q);
    assign qual  = same && (stab_cnt == QUAL_AT);
    assign blank = (eff == SEG_BLANK);

    seg7_decode u_decode (
        .seg    (eff),
        .nibble (nibble),
        .legal  (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= SEG_BLANK;
            stab_cnt <= '0;
        end else begin
            seg_q <= eff;
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 8'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        asm_d       = asm_q;
        data_d      = out_data;
        valid_d     = out_valid;
        err_d       = 1'b0;
        ovf_d       = 1'b0;
        shifted     = (asm_q << WIDTH) | WORD_W'(nibble);
        case (state_q)
            WAIT_BLANK: begin
                if (qual && blank)
                    state_d = ARMED;
            end
            ARMED: begin
                if (qual && !blank) begin
                    if (legal) begin
                        if (digit_cnt_q == LAST_DIGIT) begin
                            data_d      = shifted;
                            valid_d     = 1'b1;
                            digit_cnt_d = '0;
                            asm_d       = '0;
                            state_d     = HOLD;
                        end else begin
                            asm_d       = shifted;
                            digit_cnt_d = digit_cnt_q + 4'd1;
                            state_d     = WAIT_BLANK;
                        end
                    end else begin
                        err_d       = 1'b1;
                        digit_cnt_d = '0;
                        asm_d       = '0;
                        state_d     = WAIT_BLANK;
                    end
                end
            end
            HOLD: begin
                if (qual && !blank)
                    ovf_d = 1'b1;
                if (out_valid && out_ready) begin
                    valid_d = 1'b0;
                    state_d = WAIT_BLANK;
                end
            end
            default: state_d = WAIT_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_BLANK;
            digit_cnt_q <= '0;
            asm_q       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            asm_q       <= asm_d;
            out_data    <= data_d;
            out_valid   <= valid_d;
            err         <= err_d;
            ovf         <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seg7_word_receiver.sv
// Self-checking bench for seg7_word_receiver: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a run-length/queue reference model.
module tb_seg7_word_receiver;

    localparam int N    = 4;
    localparam int S    = 3;
    localparam int QLEN = (S >= 2) ? S : 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        out_ready = 1'b0;
    logic [6:0]  seg_in = 7'h00;
    logic [15:0] out_data;
    logic        out_valid, err, ovf;

    always #5 clk = ~clk;

    seg7_word_receiver #(.WIDTH(4), .NIBBLES(N), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .enable    (enable),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .ovf       (ovf)
    );

    logic [6:0] pats [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (pats[i] == p) return i;
        return -1;
    endfunction

    // Reference model: a pattern qualifies when its run of identical samples reaches QLEN.
    logic [6:0]  run_val;
    int          run_len;
    int          mode;          // 0 waiting for blank, 1 armed, 2 holding a word
    int          digits[$];
    logic [15:0] m_data;
    bit          m_valid, m_err, m_ovf, started;
    logic [6:0]  m_eff;
    int          m_dig;
    bit          m_q;

    always @(posedge clk) begin
        m_eff = enable ? seg_in : 7'h00;
        if (rst) begin
            started = 1; run_val = 7'h00; run_len = 1; mode = 0;
            digits.delete(); m_data = 16'h0; m_valid = 0; m_err = 0; m_ovf = 0;
        end else begin
            m_err = 0; m_ovf = 0;
            if (m_eff == run_val) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_val = m_eff; run_len = 1;
            end
            m_q   = (run_len == QLEN);
            m_dig = decode(m_eff);
            case (mode)
                0: if (m_q && m_eff == 7'h00) mode = 1;
                1: if (m_q && m_eff != 7'h00) begin
                    if (m_dig >= 0) begin
                        digits.push_back(m_dig);
                        if (digits.size() == N) begin
                            m_data = 16'h0;
                            foreach (digits[i]) m_data = (m_data << 4) | 16'(digits[i]);
                            digits.delete();
                            m_valid = 1; mode = 2;
                        end else mode = 0;
                    end else begin
                        m_err = 1; digits.delete(); mode = 0;
                    end
                end
                default: begin
                    if (m_q && m_eff != 7'h00) m_ovf = 1;
                    if (m_valid && out_ready) begin m_valid = 0; mode = 0; end
                end
            endcase
        end
    end

    int          word_cnt, err_cnt, ovf_cnt;
    logic [15:0] last_word;
    bit          prev_valid;

    always @(negedge clk) begin
        if (started) begin
            check("out_data", out_data, m_data);
            check("out_valid", out_valid, m_valid);
            check("err", err, m_err);
            check("ovf", ovf, m_ovf);
            check("err_ovf_exclusive", err & ovf, 0);
            if (out_valid && !prev_valid) word_cnt++;
            if (out_valid) last_word = out_data;
            if (err) err_cnt++;
            if (ovf) ovf_cnt++;
            prev_valid = out_valid;
        end
    end

    task automatic clear_stats();
        word_cnt = 0; err_cnt = 0; ovf_cnt = 0; last_word = 16'h0;
    endtask

    task automatic step(input logic [6:0] p, input int n);
        repeat (n) begin
            seg_in = p;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [6:0] p);
        step(p, S);
        step(7'h00, S);
    endtask

    initial begin
        clear_stats();
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_data", out_data, 16'h0);
        check("reset_out_valid", out_valid, 0);
        check("reset_err", err, 0);
        check("reset_ovf", ovf, 0);
        rst = 1'b0;
        step(7'h00, S);

        // No stall: word 0123, valid exactly when the last digit qualifies.
        out_ready = 1'b1;
        clear_stats();
        send(7'h7E); send(7'h30); send(7'h6D);
        step(7'h79, 2);
        #1 check("t1_valid_not_early", out_valid, 0);
        step(7'h79, 1);
        #1 check("t1_valid_on_time", out_valid, 1);
        check("t1_data", out_data, 16'h0123);
        step(7'h00, S);
        #1 check("t1_word_cnt", word_cnt, 1);

        // Stall with ready low, overflow digit, then handshake.
        out_ready = 1'b0;
        clear_stats();
        send(7'h47); send(7'h4F); send(7'h3D);
        step(7'h4E, S);
        #1 check("t2_valid", out_valid, 1);
        check("t2_data", out_data, 16'hFEDC);
        step(7'h00, 10);
        #1 check("t2_valid_held", out_valid, 1);
        check("t2_data_held", out_data, 16'hFEDC);
        step(7'h7F, S);
        step(7'h00, S);
        #1 check("t2_ovf_cnt", ovf_cnt, 1);
        check("t2_err_cnt", err_cnt, 0);
        check("t2_data_after_ovf", out_data, 16'hFEDC);
        out_ready = 1'b1;
        step(7'h00, 1);
        #1 check("t2_valid_dropped", out_valid, 0);
        check("t2_data_kept", out_data, 16'hFEDC);

        // Glitch of S-1 samples is ignored; a fresh blank is needed after the handshake.
        step(7'h01, 1);
        step(7'h00, S);
        clear_stats();
        step(7'h33, S - 1);
        step(7'h00, S);
        send(7'h33); send(7'h7E); send(7'h30); send(7'h6D);
        #1 check("t3_word", last_word, 16'h4012);
        check("t3_word_cnt", word_cnt, 1);
        check("t3_err_cnt", err_cnt, 0);

        // Illegal pattern discards the partial word.
        clear_stats();
        send(7'h30); send(7'h6D);
        send(7'h01);
        #1 check("t4_err_cnt", err_cnt, 1);
        send(7'h5B); send(7'h5F); send(7'h70); send(7'h7F);
        #1 check("t4_word", last_word, 16'h5678);
        check("t4_word_cnt", word_cnt, 1);

        // Long hold of one digit is accepted once.
        clear_stats();
        step(7'h5B, 12);
        step(7'h00, S);
        send(7'h30); send(7'h6D); send(7'h79);
        #1 check("t5_word", last_word, 16'h5123);
        check("t5_word_cnt", word_cnt, 1);

        // Reset mid-word.
        clear_stats();
        send(7'h30); send(7'h6D); send(7'h79);
        rst = 1'b1;
        step(7'h00, 2);
        #1 check("t6_rst_data", out_data, 16'h0);
        check("t6_rst_valid", out_valid, 0);
        rst = 1'b0;
        step(7'h00, S);
        send(7'h7B); send(7'h77); send(7'h1F); send(7'h4E);
        #1 check("t6_word", last_word, 16'h9ABC);
        check("t6_word_cnt", word_cnt, 1);

        // Disabled input reads as blank.
        clear_stats();
        enable = 1'b0;
        step(7'h7F, 6);
        enable = 1'b1;
        step(7'h00, S);
        send(7'h3D); send(7'h4F); send(7'h47); send(7'h7E);
        #1 check("t7_word", last_word, 16'hDEF0);
        check("t7_word_cnt", word_cnt, 1);

        // Randomized traffic, checked every cycle against the model.
        for (int t = 0; t < 400; t++) begin
            int kind;
            logic [6:0] p;
            kind      = int'($urandom_range(0, 99));
            out_ready = ($urandom_range(0, 1) == 1);
            enable    = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            if (kind < 70)      p = pats[$urandom_range(0, 15)];
            else if (kind < 80) p = 7'($urandom_range(0, 127));
            else                p = pats[$urandom_range(0, 15)];
            if (kind >= 80) step(p, int'($urandom_range(1, S - 1)));
            else            step(p, int'($urandom_range(1, S + 2)));
            rst = 1'b0;
            step(7'h00, int'($urandom_range(1, S + 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_word_receiver.md
# seg7_word_receiver

Receive-side counterpart to the ALU's 7-segment display encoder. Samples a 7-segment pattern bus, debounces each pattern, decodes it back to a hex nibble and assembles NIBBLES consecutive digits into one word. Each digit is delimited by a blank (all segments off). Completed words are presented on a valid/ready output. Used as a display-loopback checker and as a segment-bus capture front end.

## Interface

- WIDTH, 4: bits per decoded digit; fixed at 4.
- NIBBLES, 4: digits per assembled word; range 1–8.
- STABLE_CYCLES, 3: consecutive identical samples needed to qualify a pattern; range 1–255.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  {a,b,c,d,e,f,g}; a is the MSB.
- enable  in  1  when low, seg_in is treated as blank.
- out_data  out  NIBBLES*WIDTH  assembled word; the first received digit is the most significant nibble.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- err  out  1  one-cycle pulse: an illegal pattern was qualified.
- ovf  out  1  one-cycle pulse: a digit was qualified while in HOLD and was dropped.

## Operation

- Effective input: eff = enable ? seg_in : 7'h00.
- Input register: seg_q <= eff every cycle.
- Stability counter: cleared to 0 when eff != seg_q; otherwise increments, saturating at STABLE_CYCLES.
- Qualification: eff is qualified on the edge at which the counter reaches STABLE_CYCLES-1 with eff == seg_q. With STABLE_CYCLES=1, any eff equal to seg_q qualifies. A qualified pattern fires only once per stable run.
- Legal digit patterns (hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, B=1F, C=4E, D=3D, E=4F, F=47
- Blank is 00. Any other value is illegal.
- FSM states:
  - WAIT_BLANK (reset state):
    - qualified blank → ARMED.
    - qualified digit or illegal pattern → ignored; stay.
  - ARMED:
    - qualified legal digit → shift it into the assembly register and increment digit_cnt. If digit_cnt reaches NIBBLES, load out_data, assert out_valid, clear digit_cnt, go to HOLD. Otherwise go to WAIT_BLANK.
    - qualified illegal pattern → pulse err, clear digit_cnt and the assembly register, go to WAIT_BLANK.
    - qualified blank → stay.
  - HOLD:
    - out_valid && out_ready → clear out_valid on that edge, go to WAIT_BLANK.
    - qualified non-blank pattern in HOLD → pulse ovf; the digit is dropped and no err is raised.
    - the stability counter keeps running in HOLD.
- out_data holds its value after the handshake until the next word loads.
- Reset mid-word: the partial word is discarded.

## Timing

- Reset values:
  - out_data = 0, out_valid = 0, err = 0, ovf = 0.
  - state = WAIT_BLANK, digit_cnt = 0, counter = 0, seg_q = 00.
- Digit latency: a pattern first present before edge k qualifies at edge k+STABLE_CYCLES-1. Its effect (shift, err, out_valid) is visible after that edge.
- The last digit's qualifying edge also sets out_valid, with zero extra latency.
- out_valid stays high until the handshake edge and never drops without out_ready.
- out_ready is ignored while out_valid is low.
- Glitches shorter than STABLE_CYCLES samples are never qualified.
- err and ovf are exactly one cycle wide and never assert together.
- Minimum per-digit time: 2*STABLE_CYCLES cycles (digit plus blank).
- A blank that qualifies during HOLD has no effect. After the handshake, WAIT_BLANK still requires a fresh blank qualification.
- rst takes priority over every other event.

## Structure

- Package seg7_pkg holds:
  - the 16 segment-pattern constants and SEG_BLANK = 7'h00;
  - the FSM state enum (WAIT_BLANK, ARMED, HOLD).
- Sub-module seg7_decode: combinational, seg[6:0] → nibble[3:0] plus legal. Instantiated once on eff.
- The top level contains the input register, stability counter, FSM, assembly shift register and output register.

## Test plan

- Defaults, no stall (out_ready=1). Drive 7E,00,30,00,6D,00,79, each held 3 cycles → out_valid pulses once with out_data=16'h0123, 2 cycles after 79 first appears.
- Stall. Send 47,00,4F,00,3D,00,4E (F,E,D,C) with out_ready=0 for 10 cycles → out_data=16'hFEDC; out_valid stays high and the value stays stable. Then a 7F held 3 cycles → ovf pulses once. Raise out_ready → out_valid drops after one edge.
- Glitch. Hold 33 for 2 cycles, then 00 → no shift, no err. Hold 33 for 3 cycles → digit 4 accepted.
- Illegal pattern. After digits 1 and 2, hold 7'h01 for 3 cycles → err pulses one cycle. Then send 4 digits 5,6,7,8 → out_data=16'h5678 with no leftover 1 or 2.
- Repeated digit without blank. Hold 5B for 12 cycles → exactly one digit 5 accepted.
- Reset and enable:
  - rst asserted after 3 digits → all outputs 0; the next 4 digits form a clean word.
  - enable=0 while 7F is driven → treated as blank; no digit accepted.
